exp: RTL and testbench



---
 rtl/exp_pkg.sv | 50 +++++
 rtl/exp_lut.sv | 32 +++
 rtl/exp.sv | 129 ++++++++++++
 tb/tb_exp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// -----------------------------------------------------------------------------
// exp_pkg
// Shared constants and elaboration-time helpers for the antilog unit.
//   EXP_FRAC_BITS : fraction bits of the 16-bit log code
//   EXP_LUT_WIDTH : width of each mantissa entry
//   EXP_LUT_LEN   : number of mantissa entries (2^EXP_FRAC_BITS)
//   EXP_E_W       : width of the exponent field of the log code
// The helper functions build the mantissa table from its defining formula,
// M[f] = round(2^(f/2^FRAC_BITS) * 2^(LUT_WIDTH-1)), using wide integer
// fixed point so the table is exact to well below half an LSB.
// No ports.
// -----------------------------------------------------------------------------
package exp_pkg;

   localparam int EXP_FRAC_BITS = 10;
   localparam int EXP_LUT_WIDTH = 16;
   localparam int EXP_LUT_LEN   = 1 << EXP_FRAC_BITS;
   localparam int EXP_E_W       = 16 - EXP_FRAC_BITS;

   // Fixed-point position used by the table generator (Q60 in 128 bits).
   localparam int EXP_Q = 60;

   // ln(2) in Q60 from the series ln2 = sum 1/(k*2^k).
   function automatic logic [127:0] ln2_q();
      logic [127:0] acc;
      acc = 128'd0;
      for (int k = 1; k <= 64; k++) begin
         acc = acc + ((128'd1 << EXP_Q) / (128'(k) << k));
      end
      return acc;
   endfunction

   // Rounded mantissa for fraction f: 2^(f/2^frac_bits) = e^(f*ln2/2^frac_bits),
   // evaluated with a Taylor series in Q60 and rounded to lut_width-1 fraction bits.
   function automatic logic [127:0] exp2_entry(input int f, input int frac_bits,
                                              input int lut_width, input logic [127:0] ln2);
      logic [127:0] y;
      logic [127:0] term;
      logic [127:0] sum;
      y    = (128'(f) * ln2) >> frac_bits;
      term = 128'd1 << EXP_Q;
      sum  = term;
      for (int n = 1; n <= 40; n++) begin
         term = ((term * y) >> EXP_Q) / 128'(n);
         sum  = sum + term;
      end
      return (sum + (128'd1 << (EXP_Q - lut_width))) >> (EXP_Q - lut_width + 1);
   endfunction

endpackage

// File: rtl/exp_lut.sv
// -----------------------------------------------------------------------------
// exp_lut
// Asynchronous-read mantissa ROM for the antilog unit. Entry f holds
// round(2^(f/2^FRAC_W) * 2^(LUT_W-1)); entry 0 is 2^(LUT_W-1).
// Ports:
//   i_addr  [FRAC_W-1:0]  fraction field of the log code
//   o_data  [LUT_W-1:0]   mantissa M[i_addr]
// -----------------------------------------------------------------------------
module exp_lut
   import exp_pkg::*;
#(
   parameter int FRAC_W = EXP_FRAC_BITS,
   parameter int LUT_W  = EXP_LUT_WIDTH
) (
   input  logic [FRAC_W-1:0] i_addr,
   output logic [LUT_W-1:0]  o_data
);

   localparam int               LEN = 1 << FRAC_W;
   localparam logic [127:0]     LN2 = ln2_q();

   logic [LUT_W-1:0] w_rom [LEN];

   // Every entry is an elaboration-time constant, so this is a pure ROM.
   for (genvar g = 0; g < LEN; g++) begin : g_rom
      localparam logic [LUT_W-1:0] M_G = LUT_W'(exp2_entry(g, FRAC_W, LUT_W, LN2));
      assign w_rom[g] = M_G;
   end

   assign o_data = w_rom[i_addr];

endmodule

// File: rtl/exp.sv
// -----------------------------------------------------------------------------
// exp
// Two-stage pipelined antilog: converts a 16-bit log code {e, f} into the
// linear magnitude floor(M[f] * 2^e / 2^(LUT_WIDTH-1)), saturating to all
// ones when e >= DATA_WIDTH, with valid/ready streams on both sides.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   input_tdata[15:0]            log code ([15:FRAC_BITS] = e, rest = f)
//   input_tvalid/tready/tlast    input stream handshake and end-of-vector
//   output_tdata[DATA_WIDTH-1:0] linear result
//   output_tvalid/tready/tlast   output stream handshake and end-of-vector
//   sat_clear                    clears sat_count (wins over an increment)
//   sat_count[15:0]              saturated-beat count, sticks at 0xFFFF
// -----------------------------------------------------------------------------
module exp
   import exp_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = EXP_FRAC_BITS,
   parameter int LUT_WIDTH  = EXP_LUT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           input_tdata,
   input  logic                  input_tvalid,
   output logic                  input_tready,
   input  logic                  input_tlast,
   output logic [DATA_WIDTH-1:0] output_tdata,
   output logic                  output_tvalid,
   output logic                  output_tlast,
   input  logic                  output_tready,
   input  logic                  sat_clear,
   output logic [15:0]           sat_count
);

   localparam int E_W    = 16 - FRAC_BITS;
   localparam int WIDE_W = DATA_WIDTH + LUT_WIDTH;

   logic                  w_s2_ready;
   logic                  w_in_ready;
   logic [LUT_WIDTH-1:0]  w_lut_m;
   logic [WIDE_W-1:0]     w_wide;
   logic [DATA_WIDTH-1:0] w_result;
   logic                  w_sat;

   logic                  r_s1_v;
   logic [LUT_WIDTH-1:0]  r_s1_m;
   logic [E_W-1:0]        r_s1_e;
   logic                  r_s1_last;

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_last;
   logic [15:0]           r_sat_count;

   exp_lut #(
      .FRAC_W (FRAC_BITS),
      .LUT_W  (LUT_WIDTH)
   ) u_lut (
      .i_addr (input_tdata[FRAC_BITS-1:0]),
      .o_data (w_lut_m)
   );

   // Ready chain: each stage can load if it is empty or the stage after it is moving.
   // Depends on output_tready but never on input_tvalid.
   assign w_s2_ready = !r_out_valid || output_tready;
   assign w_in_ready = !r_s1_v || w_s2_ready;

   // Shift the mantissa into place in a wide intermediate, or clamp on exponent overflow.
   always_comb begin
      w_wide = WIDE_W'(r_s1_m) << r_s1_e;
      if (32'(r_s1_e) >= 32'(DATA_WIDTH)) begin
         w_sat    = 1'b1;
         w_result = '1;
      end else begin
         w_sat    = 1'b0;
         w_result = DATA_WIDTH'(w_wide >> (LUT_WIDTH - 1));
      end
   end

   // S1: capture mantissa, exponent and tlast; holds everything while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_v    <= 1'b0;
         r_s1_m    <= '0;
         r_s1_e    <= '0;
         r_s1_last <= 1'b0;
      end else if (w_in_ready) begin
         r_s1_v    <= input_tvalid;
         r_s1_m    <= w_lut_m;
         r_s1_e    <= input_tdata[15:FRAC_BITS];
         r_s1_last <= input_tlast;
      end
   end

   // S2 output register: data only changes when a real beat moves in, so a
   // bubble never disturbs the last presented value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_s2_ready) begin
         r_out_valid <= r_s1_v;
         r_out_last  <= r_s1_v & r_s1_last;
         if (r_s1_v) begin
            r_out_data <= w_result;
         end
      end
   end

   // Saturation counter: clear wins, increments on each saturated beat entering S2, sticks at max.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_count <= 16'd0;
      end else if (sat_clear) begin
         r_sat_count <= 16'd0;
      end else if (w_s2_ready && r_s1_v && w_sat && (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign input_tready  = w_in_ready;
   assign output_tdata  = r_out_data;
   assign output_tvalid = r_out_valid;
   assign output_tlast  = r_out_last;
   assign sat_count     = r_sat_count;

endmodule

// File: tb/tb_exp.sv
// -----------------------------------------------------------------------------
// tb_exp
// Scoreboard bench for exp: the driver pushes hand-computed expected beats as
// they are accepted, an independent monitor pops and compares whenever an
// output beat is transferred, and also checks output stability under stalls.
// -----------------------------------------------------------------------------
module tb_exp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] input_tdata = 16'h0000;
   logic        input_tvalid = 1'b0;
   logic        input_tready;
   logic        input_tlast = 1'b0;
   logic [31:0] output_tdata;
   logic        output_tvalid;
   logic        output_tlast;
   logic        output_tready = 1'b1;
   logic        sat_clear = 1'b0;
   logic [15:0] sat_count;

   exp #(.DATA_WIDTH(32), .FRAC_BITS(10), .LUT_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .input_tdata   (input_tdata),
      .input_tvalid  (input_tvalid),
      .input_tready  (input_tready),
      .input_tlast   (input_tlast),
      .output_tdata  (output_tdata),
      .output_tvalid (output_tvalid),
      .output_tlast  (output_tlast),
      .output_tready (output_tready),
      .sat_clear     (sat_clear),
      .sat_count     (sat_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_acc = 0;
   int   n_del = 0;
   int   ready_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: never ready
   bit   chk_lat = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic set_ready();
      if (ready_mode == 0)      output_tready = 1'b1;
      else if (ready_mode == 1) output_tready = ((cyc % 3) == 0);
      else                      output_tready = 1'b0;
   endtask

   // Offer one beat until accepted; the expected result is queued on acceptance.
   task automatic send(input logic [15:0] code, input logic last, input logic [31:0] expv);
      int  waitc;
      bit  done;
      logic exp_rdy;
      exp_t e;
      waitc = 0;
      done  = 1'b0;
      while (!done) begin
         @(negedge clk);
         set_ready();
         input_tdata  = code;
         input_tvalid = 1'b1;
         input_tlast  = last;
         #1;
         exp_rdy = !(((n_acc - n_del) == 2) && !output_tready);
         check("input_tready", input_tready, exp_rdy);
         if (input_tready) begin
            e.data = expv;
            e.last = last;
            e.cyc  = cyc;
            q.push_back(e);
            n_acc++;
            done = 1'b1;
         end else begin
            waitc++;
            if (waitc > 50) begin
               check("send_timeout", input_tready, 1'b1);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         set_ready();
         input_tvalid = 1'b0;
         input_tlast  = 1'b0;
      end
   endtask

   // Monitor: pops on every output transfer, checks holds during stalls.
   initial begin
      bit          prev_stall;
      logic [31:0] h_data;
      logic        h_last;
      exp_t        e;
      prev_stall = 1'b0;
      h_data = 32'h0;
      h_last = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", output_tvalid, 1'b1);
               check("stall_data", output_tdata, h_data);
               check("stall_last", output_tlast, h_last);
            end
            if (output_tvalid && output_tready) begin
               if (q.size() == 0) begin
                  check("spurious_out", output_tvalid, 1'b0);
               end else begin
                  e = q.pop_front();
                  n_del++;
                  check("out_data", output_tdata, e.data);
                  check("out_last", output_tlast, e.last);
                  if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
               end
            end
            prev_stall = output_tvalid && !output_tready;
            h_data = output_tdata;
            h_last = output_tlast;
         end
      end
   end

   logic [15:0] bp_code [8];
   logic [31:0] bp_exp  [8];

   initial begin
      int w;
      bp_code[0] = 16'h0000; bp_exp[0] = 32'd1;
      bp_code[1] = 16'h0400; bp_exp[1] = 32'd2;
      bp_code[2] = 16'h0200; bp_exp[2] = 32'd1;        // sqrt2 with e=0 floors to 1
      bp_code[3] = 16'h3E00; bp_exp[3] = 32'd46341;    // e=15 exposes M[512] directly
      bp_code[4] = 16'h1400; bp_exp[4] = 32'd32;
      bp_code[5] = 16'h2A00; bp_exp[5] = 32'd1448;
      bp_code[6] = 16'h4000; bp_exp[6] = 32'd65536;
      bp_code[7] = 16'h7C00; bp_exp[7] = 32'h8000_0000;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", output_tvalid, 1'b0);
      check("rst_out_data", output_tdata, 32'h0);
      check("rst_out_last", output_tlast, 1'b0);
      check("rst_sat_count", sat_count, 16'h0);
      check("rst_in_ready", input_tready, 1'b1);

      // Basic values with latency check, always ready
      ready_mode = 0;
      chk_lat = 1'b1;
      send(16'h0000, 1'b0, 32'd1);
      send(16'h0400, 1'b0, 32'd2);
      send(16'h1400, 1'b0, 32'd32);
      send(16'h7C00, 1'b0, 32'h8000_0000);
      send(16'h2A00, 1'b1, 32'd1448);
      idle(4);
      chk_lat = 1'b0;

      // Backpressure: 8 beats, tlast on the last, ready pattern 1,0,0
      ready_mode = 1;
      for (int i = 0; i < 8; i++) send(bp_code[i], (i == 7), bp_exp[i]);
      idle(30);
      ready_mode = 0;
      idle(2);
      check("bp_drained", n_del, n_acc);

      // Reset mid-stream with two beats in flight
      ready_mode = 2;
      send(16'h0400, 1'b0, 32'd2);
      send(16'h0800, 1'b1, 32'd4);
      @(negedge clk);
      set_ready();
      input_tvalid = 1'b0;
      input_tlast  = 1'b0;
      #1;
      check("full_stall_ready", input_tready, 1'b0);
      rst = 1'b1;
      q.delete();
      n_del = n_acc;
      @(negedge clk);
      rst = 1'b0;
      ready_mode = 0;
      set_ready();
      #1;
      check("midrst_out_valid", output_tvalid, 1'b0);
      check("midrst_in_ready", input_tready, 1'b1);
      idle(6);

      // Saturation and clear colliding with an increment
      send(16'h8000, 1'b0, 32'hFFFF_FFFF);
      idle(3);
      check("sat_count_one", sat_count, 16'd1);
      send(16'hFC00, 1'b0, 32'hFFFF_FFFF);
      @(negedge clk);
      input_tvalid = 1'b0;
      sat_clear = 1'b1;
      @(negedge clk);
      sat_clear = 1'b0;
      idle(2);
      check("sat_clear_wins", sat_count, 16'd0);

      // Counter sticks at 0xFFFF
      for (int i = 0; i < 65540; i++) send(16'h8000, 1'b0, 32'hFFFF_FFFF);
      idle(4);
      check("sat_count_stick", sat_count, 16'hFFFF);

      // Drain
      w = 0;
      while ((q.size() != 0) && (w < 100)) begin
         idle(1);
         w++;
      end
      check("final_drain", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
